// File: rtl/stacker_row_engine.sv
// Stacker game control: moving block pattern, per-row placement and trimming,
// win/lose detection and array clear. Optional macro STACKER_SHRINK_EN narrows the pattern at rows 3 and 6.
module stacker_row_engine #(
  parameter logic [7:0] START_PATTERN = 8'b00111000,
  parameter int         NUM_ROWS      = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn,
  input  logic       update_clk,
  output logic [7:0] val,
  output logic [2:0] row_index,
  output logic       write_strobe,
  output logic       clr_array,
  output logic [2:0] state
);

  // Handshake: write_strobe is a one-cycle pulse qualifying val/row_index
  // (display row 7-row_index); clr_array is a one-cycle pulse. No ready exists:
  // the consumer must accept every pulse on the edge after it is raised.

  typedef enum logic [2:0] {
    QINIT  = 3'd0,
    QMOVE  = 3'd1,
    QPLACE = 3'd2,
    QNEXT  = 3'd3,
    QWIN   = 3'd4,
    QLOSE  = 3'd5
  } state_t;

  localparam logic       DIR_LEFT  = 1'b0;
  localparam logic       DIR_RIGHT = 1'b1;
  localparam logic [2:0] LAST_ROW  = 3'(NUM_ROWS - 1);

  state_t     state_q;
  logic       dir;
  logic [7:0] prev_row;

  logic [7:0] trimmed;
  logic [2:0] next_row;
  logic [7:0] next_val;
  logic [7:0] shifted;
  logic       next_dir;

  assign state = state_q;

  function automatic logic [7:0] drop_leftmost(input logic [7:0] v);
    logic [7:0] r;
    logic       done;
    r    = v;
    done = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      if (!done && v[i]) begin
        r[i] = 1'b0;
        done = 1'b1;
      end
    end
    return r;
  endfunction

  always_comb begin
    trimmed  = val & prev_row;
    next_row = (row_index == LAST_ROW) ? row_index : row_index + 3'd1;
    next_val = val;
`ifdef STACKER_SHRINK_EN
    // v & (v-1) is nonzero exactly when more than one bit is set.
    if ((next_row == 3'd3 || next_row == 3'd6) && ((val & (val - 8'd1)) != 8'd0))
      next_val = drop_leftmost(val);
`else
    next_val = val;
`endif
  end

  // Bounce happens on the tick that finds the pattern against an edge,
  // so the pattern never idles at the wall.
  always_comb begin
    shifted  = val;
    next_dir = dir;
    if (dir == DIR_LEFT && val[7]) begin
      next_dir = DIR_RIGHT;
      shifted  = val >> 1;
    end else if (dir == DIR_RIGHT && val[0]) begin
      next_dir = DIR_LEFT;
      shifted  = val << 1;
    end else if (dir == DIR_LEFT) begin
      shifted  = val << 1;
    end else begin
      shifted  = val >> 1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= QINIT;
      val          <= 8'h00;
      row_index    <= 3'd0;
      write_strobe <= 1'b0;
      clr_array    <= 1'b0;
      dir          <= DIR_LEFT;
      prev_row     <= 8'hFF;
    end else begin
      write_strobe <= 1'b0;
      clr_array    <= 1'b0;
      case (state_q)
        QINIT: begin
          if (btn) begin
            val          <= START_PATTERN;
            row_index    <= 3'd0;
            prev_row     <= 8'hFF;
            dir          <= DIR_LEFT;
            write_strobe <= 1'b1;
            state_q      <= QMOVE;
          end
        end
        QMOVE: begin
          if (btn) begin
            state_q <= QPLACE;
          end else if (update_clk) begin
            val          <= shifted;
            dir          <= next_dir;
            write_strobe <= 1'b1;
          end
        end
        QPLACE: begin
          val          <= trimmed;
          write_strobe <= 1'b1;
          if (trimmed == 8'h00)
            state_q <= QLOSE;
          else if (row_index == LAST_ROW)
            state_q <= QWIN;
          else
            state_q <= QNEXT;
        end
        QNEXT: begin
          // The row below remembers the unshrunk trimmed pattern.
          prev_row     <= val;
          row_index    <= next_row;
          val          <= next_val;
          dir          <= DIR_LEFT;
          write_strobe <= 1'b1;
          state_q      <= QMOVE;
        end
        QWIN, QLOSE: begin
          if (btn) begin
            clr_array <= 1'b1;
            state_q   <= QINIT;
          end
        end
        default: begin
          clr_array <= 1'b1;
          state_q   <= QINIT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stacker_row_engine.sv
// Directed bench for stacker_row_engine: move, bounce, place, trim, win, lose, reset.
module tb_stacker_row_engine;

  logic       clk;
  logic       reset;
  logic       btn;
  logic       update_clk;
  logic [7:0] val;
  logic [2:0] row_index;
  logic       write_strobe;
  logic       clr_array;
  logic [2:0] state;

  int total;
  int bad;

  stacker_row_engine dut (
    .clk          (clk),
    .reset        (reset),
    .btn          (btn),
    .update_clk   (update_clk),
    .val          (val),
    .row_index    (row_index),
    .write_strobe (write_strobe),
    .clr_array    (clr_array),
    .state        (state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // drivers: apply inputs for one posedge, sample 1 ns later
  task automatic cycle(input logic b, input logic u);
    btn        = b;
    update_clk = u;
    @(posedge clk);
    #1;
    btn        = 1'b0;
    update_clk = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cycle(1'b0, 1'b0);
    reset = 1'b0;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic [2:0] st, input logic [7:0] v,
                            input logic [2:0] row, input logic ws, input logic clr);
    check({tag, ".state"}, {5'd0, state}, {5'd0, st});
    check({tag, ".val"}, val, v);
    check({tag, ".row"}, {5'd0, row_index}, {5'd0, row});
    check({tag, ".ws"}, {7'd0, write_strobe}, {7'd0, ws});
    check({tag, ".clr"}, {7'd0, clr_array}, {7'd0, clr});
  endtask

  // scoreboard: expected trimmed pattern per row for the perfect stack
  function automatic logic [7:0] perfect_val(input int r);
`ifdef STACKER_SHRINK_EN
    if (r >= 6) return 8'b00001000;
    if (r >= 3) return 8'b00011000;
    return 8'b00111000;
`else
    return (r >= 0) ? 8'b00111000 : 8'h00;
`endif
  endfunction

  logic [7:0] exp_q[$];
  logic [7:0] exp_v;

  initial begin
    total      = 0;
    bad        = 0;
    reset      = 1'b0;
    btn        = 1'b0;
    update_clk = 1'b0;

    do_reset();
    check_outs("reset", 3'd0, 8'h00, 3'd0, 1'b0, 1'b0);

    // start, then ticks with a bounce off the left wall
    cycle(1'b1, 1'b0);
    check_outs("start", 3'd1, 8'b00111000, 3'd0, 1'b1, 1'b0);
    cycle(1'b0, 1'b0);
    check("idle.ws", {7'd0, write_strobe}, 8'd0);
    exp_q = '{8'b01110000, 8'b11100000, 8'b01110000, 8'b00111000,
              8'b00011100, 8'b00001110, 8'b00000111};
    foreach (exp_q[i]) begin
      cycle(1'b0, 1'b1);
      check_outs($sformatf("tick%0d", i), 3'd1, exp_q[i], 3'd0, 1'b1, 1'b0);
    end

    // place row 0 at 00000111, then row 1 moved to 11100000 -> lose
    cycle(1'b1, 1'b0);
    check_outs("place0", 3'd2, 8'b00000111, 3'd0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0);
    check_outs("trim0", 3'd3, 8'b00000111, 3'd0, 1'b1, 1'b0);
    cycle(1'b0, 1'b0);
    check_outs("next0", 3'd1, 8'b00000111, 3'd1, 1'b1, 1'b0);
    exp_q = '{8'b00001110, 8'b00011100, 8'b00111000, 8'b01110000, 8'b11100000};
    foreach (exp_q[i]) begin
      cycle(1'b0, 1'b1);
      check($sformatf("r1tick%0d", i), val, exp_q[i]);
    end
    cycle(1'b1, 1'b0);
    cycle(1'b0, 1'b0);
    check_outs("lose", 3'd5, 8'h00, 3'd1, 1'b1, 1'b0);
    cycle(1'b0, 1'b1);
    check_outs("lose_hold", 3'd5, 8'h00, 3'd1, 1'b0, 1'b0);
    cycle(1'b1, 1'b0);
    check_outs("lose_clr", 3'd0, 8'h00, 3'd1, 1'b0, 1'b1);
    cycle(1'b0, 1'b0);
    check("clr_single", {7'd0, clr_array}, 8'd0);

    // simultaneous btn + tick: btn wins, no shift
    cycle(1'b1, 1'b0);
    check_outs("restart", 3'd1, 8'b00111000, 3'd0, 1'b1, 1'b0);
    cycle(1'b1, 1'b1);
    check_outs("both", 3'd2, 8'b00111000, 3'd0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b0);
    check_outs("row1", 3'd1, 8'b00111000, 3'd1, 1'b1, 1'b0);

    // misaligned placement trims to 00110000
    cycle(1'b0, 1'b1);
    check("mis_tick", val, 8'b01110000);
    cycle(1'b1, 1'b0);
    cycle(1'b0, 1'b0);
    check_outs("mis_trim", 3'd3, 8'b00110000, 3'd1, 1'b1, 1'b0);
    cycle(1'b0, 1'b0);
    check_outs("row2", 3'd1, 8'b00110000, 3'd2, 1'b1, 1'b0);

    // climb to row 4 then reset mid-game
    for (int r = 0; r < 2; r++) begin
      cycle(1'b1, 1'b0);
      cycle(1'b0, 1'b0);
      cycle(1'b0, 1'b0);
    end
    check("mid.row", {5'd0, row_index}, 8'd4);
    check("mid.state", {5'd0, state}, 8'd1);
    do_reset();
    check_outs("midreset", 3'd0, 8'h00, 3'd0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0);
    check_outs("post_reset_start", 3'd1, 8'b00111000, 3'd0, 1'b1, 1'b0);

    // perfect stack to a win
    for (int r = 0; r < 8; r++) begin
      cycle(1'b1, 1'b0);
      cycle(1'b0, 1'b0);
      exp_v = perfect_val(r);
      check($sformatf("stack%0d", r), val, exp_v);
      if (r < 7) cycle(1'b0, 1'b0);
    end
    check_outs("win", 3'd4, perfect_val(7), 3'd7, 1'b1, 1'b0);
    cycle(1'b0, 1'b1);
    check_outs("win_hold", 3'd4, perfect_val(7), 3'd7, 1'b0, 1'b0);
    cycle(1'b1, 1'b0);
    check_outs("win_clr", 3'd0, perfect_val(7), 3'd7, 1'b0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/stacker_row_engine.md
Name: stacker_row_engine

Overview:
- Game-control stage feeding the 8x8 block-array display.
- Owns the moving block pattern, per-row placement, trimming against the row below, win/lose detection and the array-clear command.
- Consumes the debounced single-cycle button pulse and the speed tick from the display top.
- Produces the row value, row index, write strobe, clear command and state code.

Parameters:
- START_PATTERN, 8'b00111000, initial 3-block pattern loaded at game start.
- NUM_ROWS, 8, rows in the stack; last row index is NUM_ROWS-1.

Ports:
- clk  in  1  system clock (display pixel clock domain).
- reset  in  1  synchronous, active-high reset.
- btn  in  1  single-cycle debounced button pulse.
- update_clk  in  1  single-cycle move tick; rate is set externally from row_index.
- val  out  8  current row pattern; bit 7 = leftmost column.
- row_index  out  3  current row, 0 = bottom.
- write_strobe  out  1  one-cycle pulse; consumer writes val into display row (7-row_index).
- clr_array  out  1  one-cycle pulse; consumer zeroes all display rows.
- state  out  3  current state code.

Behaviour:
- All outputs are registered and update on the posedge of clk. val, row_index and write_strobe change on the same edge. The consumer samples them on the next edge.
- reset (synchronous, active-high, wins over everything): state=QINIT, val=0, row_index=0, write_strobe=0, clr_array=0, dir=LEFT, prev_row=8'hFF.
- Internal registers:
  - dir: direction of travel, 1 bit.
  - prev_row: placed pattern of the row below, 8 bits.
- State codes:
  - QINIT=0, QMOVE=1, QPLACE=2, QNEXT=3, QWIN=4, QLOSE=5.
  - Codes 6 and 7 are illegal; the FSM goes to QINIT on the next cycle.
- QINIT:
  - clr_array=1 on the first cycle after entry only.
  - On btn: val=START_PATTERN, row_index=0, prev_row=8'hFF, dir=LEFT, write_strobe=1, go to QMOVE.
- QMOVE:
  - On update_clk with no btn, the pattern moves one column and write_strobe=1.
  - If dir=LEFT and val[7]=1, set dir=RIGHT and shift right (bounce with no idle tick).
  - If dir=RIGHT and val[0]=1, set dir=LEFT and shift left.
  - Otherwise shift in dir; zeros are shifted in.
  - On btn: go to QPLACE. If btn and update_clk are both high, btn wins and no shift happens that cycle.
- QPLACE (one cycle):
  - val <= val & prev_row; write_strobe=1.
  - If the trimmed result is 0, go to QLOSE.
  - Else if row_index==NUM_ROWS-1, go to QWIN.
  - Else go to QNEXT.
- QNEXT (one cycle):
  - prev_row <= val; row_index <= row_index+1; val keeps the trimmed pattern; dir=LEFT; write_strobe=1 (shows the new row); go to QMOVE.
- QWIN / QLOSE:
  - Outputs hold and update_clk is ignored.
  - btn goes to QINIT, which clears the array.
- row_index never wraps; it saturates at NUM_ROWS-1 and is reset only in QINIT.
- btn outside QINIT, QMOVE, QWIN and QLOSE is ignored; it is not queued.
- write_strobe and clr_array are never high for two consecutive cycles. They are never high in the same cycle.

Optional Feature:
- Macro: STACKER_SHRINK_EN.
- Defined: in QNEXT, when the new row_index equals 3 or 6 and popcount(val)>1, the leftmost set bit of val is also cleared. The pattern shrinks 3->2->1 even with perfect alignment. prev_row is stored from the unshrunk trimmed value.
- Undefined: the width changes only through trimming in QPLACE.

Test Plan:
- Reset mid-game (state=QMOVE, row_index=4) -> next cycle state=0, val=0, row_index=0, no strobes. Following btn -> val=8'b00111000, write_strobe=1, state=1.
- Start, then 3 ticks -> val 00111000 -> 01110000 -> 11100000 -> 11000000? No: the third tick bounces because val[7]=1 (dir=LEFT). Checked sequence: 00111000 -> 01110000 -> 11100000, and the 3rd tick gives 01110000. One write_strobe per tick.
- Perfect stack: btn pressed immediately on each of rows 0..7 (no ticks) -> each QPLACE val=00111000, state reaches QWIN (4), row_index=7. With STACKER_SHRINK_EN, final val=00001000.
- Misaligned place: row 0 placed at 00111000, row 1 moved one tick to 01110000, then btn -> QPLACE val=00110000, row 2 starts with 00110000.
- Lose: row 0 at 00111000, row 1 moved to 11100000 then bounced to 01110000... Used vector: prev_row=00000111, val=11100000 -> QPLACE val=0, state=QLOSE (5). btn -> QINIT with a single clr_array pulse.
- Simultaneous btn+update_clk in QMOVE -> no shift, val unchanged, state=QPLACE next cycle.
